fp_arith_unit: RTL and testbench
================================

Name: fp_arith_unit

Overview:
- Single-issue IEEE-754 single-precision arithmetic block for the EX-stage FPU.
- Covers the add/sub, divide and float-to-int functions currently provided by FPAddSub, FPDiv and FPFtoI.
- Accepts one operation per start pulse, holds busy while computing, and pulses valid with the 32-bit result and a divide-by-zero flag after a fixed, op-dependent latency.

Parameters:
- ADD_LAT, 7, cycles from start to valid for add/sub; must be ≥4.
- FTOI_LAT, 6, cycles from start to valid for ftoi; must be ≥3.
- DIV_LAT, 30, cycles from start to valid for divide; must be ≥28 (radix-2 iterative core).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active high.
- start  in  1  launch operation; sampled only when busy=0.
- op  in  2  operation: 00 add, 01 sub, 10 div, 11 ftoi.
- dataa  in  32  operand A; the dividend, and the ftoi source.
- datab  in  32  operand B; the divisor; ignored for ftoi.
- result  out  32  float result, or signed int32 for ftoi.
- valid  out  1  one-cycle completion pulse.
- busy  out  1  operation in flight.
- division_by_zero  out  1  qualified by valid.

Behaviour:
- Reset (synchronous, active high, priority over everything):
  - result=0, valid=0, busy=0, division_by_zero=0.
  - An in-flight operation is aborted and never produces valid.
- Launch and timing:
  - start=1 with busy=0 at edge N latches op, dataa and datab; busy=1 from edge N.
  - At edge N+L (L per op), result and flag are updated, valid=1 for exactly one cycle, and busy=0.
  - A new start is accepted at edge N+L+1 or later. Back-to-back issue therefore costs L+1 cycles.
  - start while busy=1 is ignored. Operand changes after launch have no effect.
- Hold: result and division_by_zero hold their values until the next completion or reset. division_by_zero is rewritten on every completion (0 for non-div ops).
- Denormals: denormal inputs are flushed to signed zero. Denormal results are flushed to +0 (add/sub) or signed zero (div).
- Rounding: round-to-nearest-even for add/sub/div. Overflow gives ±Inf.
- NaN: any NaN input gives canonical NaN 0x7FC00000.
- Add/sub:
  - sub = add with datab sign inverted.
  - Exact zero result is +0, except (-0)+(-0) = -0.
  - Inf-Inf of opposite effective sign = NaN.
- Div:
  - Sign = XOR of operand signs. Mantissa via restoring division with guard, round and sticky bits.
  - division_by_zero=1 iff datab is ±0 (after flush) and dataa is not NaN. Result is ±Inf, or NaN for 0/0.
  - Inf/Inf = NaN. Inf/x = ±Inf. x/Inf = ±0.
- Ftoi:
  - Truncates toward zero.
  - |value| < 1 → 0.
  - Saturation: result > 2147483647 → 0x7FFFFFFF; result < -2147483648 → 0x80000000.
  - -2^31 exactly → 0x80000000. NaN → 0x80000000. ±Inf saturates by sign.

Test Plan:
- Reset, then add 0x3F800000 + 0x40000000 → busy high 7 cycles; valid at edge N+7; result 0x40400000; division_by_zero=0.
- Sub 0x3F800000 - 0x3F800000 → 0x00000000. Add 0x3F800000 + 0x33800000 (1 + 2^-24, tie) → 0x3F800000 (ties-to-even).
- Div 0x3F800000 / 0x40400000 → 0x3EAAAAAB at edge N+30. Div 0x40A00000 / 0x00000000 → 0x7F800000 with division_by_zero=1. Div 0x00000000 / 0x80000000 → 0x7FC00000 with division_by_zero=1.
- Ftoi 0xC0300000 (-2.75) → 0xFFFFFFFE at N+6. Ftoi 0x4F32D05E (3e9) → 0x7FFFFFFF. Ftoi 0x7FC00000 → 0x80000000.
- Start held high continuously with changing operands during a div → only the first op completes. The next launch occurs the cycle after valid. Exactly one valid pulse per accepted start.
- Assert rst at cycle 10 of a div → outputs zero next edge; no valid appears afterward. A following add completes normally.

Source files
------------

// File: rtl/fp_arith_unit.sv
// fp_arith_unit: single-precision add/sub, divide and float-to-int.
// One op in flight, fixed per-op latency, radix-2 restoring divider.
module fp_arith_unit #(
  parameter int ADD_LAT  = 7,
  parameter int FTOI_LAT = 6,
  parameter int DIV_LAT  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy,
  output logic        division_by_zero
);

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [7:0] ADD_L = 8'(ADD_LAT);
  localparam logic [7:0] FTOI_L = 8'(FTOI_LAT);
  localparam logic [7:0] DIV_L = 8'(DIV_LAT);
  localparam logic [7:0] DIV_STEPS = 8'd27;

  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [7:0]  cnt, lat;
  logic [25:0] rem, rem_nx;
  logic [26:0] quo;
  logic        q_bit;

  logic        sa, sb, is_div, is_ftoi;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf;
  logic        a_nan, b_nan;

  logic [31:0] add_res, ftoi_res, div_res, res_c;
  logic        dz_c;

  function automatic logic ovf(input logic [9:0] e);
    return !e[9] && (e[8] || (e[7:0] == 8'hFF));
  endfunction

  function automatic logic unf(input logic [9:0] e);
    return e[9] || (e == 10'd0);
  endfunction

  assign sa = a_q[31];
  assign sb = b_q[31];
  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign ma = {1'b1, a_q[22:0]};
  assign mb = {1'b1, b_q[22:0]};
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign is_div = (op_q == 2'b10);
  assign is_ftoi = (op_q == 2'b11);

  logic        sbx, a_big, s_l, found;
  logic [7:0]  e_l, e_s, d;
  logic [23:0] m_l, m_s;
  logic [26:0] m_sx, al, nm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e_n, e_r;
  logic [24:0] am;

  always_comb begin
    add_res = 32'h0;
    sbx = sb ^ op_q[0];
    a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    s_l = a_big ? sa : sbx;
    e_l = a_big ? ea : eb;
    e_s = a_big ? eb : ea;
    m_l = a_big ? ma : mb;
    m_s = a_big ? mb : ma;
    d = e_l - e_s;
    m_sx = {m_s, 3'b000};
    if (d >= 8'd27) begin
      al = 27'd1;
    end else begin
      al = m_sx >> d;
      al[0] = al[0] | (|(m_sx & ((27'd1 << d) - 27'd1)));
    end
    if (sa ^ sbx)
      sum = {1'b0, m_l, 3'b000} - {1'b0, al};
    else
      sum = {1'b0, m_l, 3'b000} + {1'b0, al};
    lz = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz = 5'(26 - i);
        found = 1'b1;
      end
    end
    if (sum[27]) begin
      nm = sum[27:1] | {26'd0, sum[0]};
      e_n = {2'b00, e_l} + 10'd1;
    end else begin
      nm = sum[26:0] << lz;
      e_n = {2'b00, e_l} - {5'd0, lz};
    end
    am = {1'b0, nm[26:3]}
       + {24'd0, nm[2] & (nm[3] | nm[1] | nm[0])};
    e_r = am[24] ? e_n + 10'd1 : e_n;
    if (am[24]) am = am >> 1;
    if (a_nan || b_nan) add_res = QNAN;
    else if (a_inf && b_inf && (sa != sbx)) add_res = QNAN;
    else if (a_inf) add_res = {sa, 8'hFF, 23'd0};
    else if (b_inf) add_res = {sbx, 8'hFF, 23'd0};
    else if (a_zero && b_zero) add_res = {sa & sbx, 31'd0};
    else if (a_zero) add_res = {sbx, b_q[30:0]};
    else if (b_zero) add_res = a_q;
    else if (sum == 28'd0) add_res = 32'h0;
    else if (ovf(e_r)) add_res = {s_l, 8'hFF, 23'd0};
    else if (unf(e_r)) add_res = 32'h0;
    else add_res = {s_l, e_r[7:0], am[22:0]};
  end

  logic [31:0] mag;

  always_comb begin
    if (ea >= 8'd150)
      mag = {8'd0, ma} << (ea - 8'd150);
    else
      mag = {8'd0, ma} >> (8'd150 - ea);
    if (a_nan) ftoi_res = 32'h80000000;
    else if (a_zero || (ea < 8'd127)) ftoi_res = 32'h0;
    else if (a_inf || (ea >= 8'd158))
      ftoi_res = sa ? 32'h80000000 : 32'h7FFFFFFF;
    else ftoi_res = sa ? -mag : mag;
  end

  assign q_bit = (rem >= {2'b00, mb});
  assign rem_nx = q_bit ? (rem - {2'b00, mb}) << 1 : rem << 1;

  logic        sd, dg, ds;
  logic [24:0] dm;
  logic [9:0]  de;

  always_comb begin
    sd = sa ^ sb;
    if (quo[26]) begin
      dm = {1'b0, quo[26:3]};
      dg = quo[2];
      ds = (|quo[1:0]) | (rem != 26'd0);
    end else begin
      dm = {1'b0, quo[25:2]};
      dg = quo[1];
      ds = quo[0] | (rem != 26'd0);
    end
    dm = dm + {24'd0, dg & (ds | dm[0])};
    de = {2'b00, ea} - {2'b00, eb} + 10'd127
       - {9'd0, ~quo[26]} + {9'd0, dm[24]};
    if (dm[24]) dm = dm >> 1;
    if (a_nan || b_nan) div_res = QNAN;
    else if ((a_inf && b_inf) || (a_zero && b_zero)) div_res = QNAN;
    else if (a_inf || b_zero) div_res = {sd, 8'hFF, 23'd0};
    else if (a_zero || b_inf) div_res = {sd, 31'd0};
    else if (ovf(de)) div_res = {sd, 8'hFF, 23'd0};
    else if (unf(de)) div_res = {sd, 31'd0};
    else div_res = {sd, de[7:0], dm[22:0]};
  end

  assign dz_c = is_div && b_zero && !a_nan;

  always_comb begin
    unique case (1'b1)
      is_div: begin
        res_c = div_res;
        lat = DIV_L;
      end
      is_ftoi: begin
        res_c = ftoi_res;
        lat = FTOI_L;
      end
      default: begin
        res_c = add_res;
        lat = ADD_L;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 32'h0;
      valid <= 1'b0;
      busy <= 1'b0;
      division_by_zero <= 1'b0;
      op_q <= 2'b00;
      a_q <= 32'h0;
      b_q <= 32'h0;
      cnt <= 8'd0;
      rem <= 26'd0;
      quo <= 27'd0;
    end else begin
      valid <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          op_q <= op;
          a_q <= dataa;
          b_q <= datab;
          cnt <= 8'd1;
          rem <= {3'b001, dataa[22:0]};
          quo <= 27'd0;
        end
      end else if (cnt == lat) begin
        busy <= 1'b0;
        valid <= 1'b1;
        result <= res_c;
        division_by_zero <= dz_c;
      end else begin
        cnt <= cnt + 8'd1;
        if (cnt <= DIV_STEPS) begin
          rem <= rem_nx;
          quo <= {quo[25:0], q_bit};
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_arith_unit.sv
// tb_fp_arith_unit: vector table, directed corner sequences and
// random ops checked against a double-precision reference model.
module tb_fp_arith_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] dataa, datab, result;
  logic        valid, busy, division_by_zero;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  always #5 clk = ~clk;

  fp_arith_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .dataa(dataa),
    .datab(datab),
    .result(result),
    .valid(valid),
    .busy(busy),
    .division_by_zero(division_by_zero)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input logic z);
    vec_t v;
    v.op = o;
    v.a = a;
    v.b = b;
    v.res = r;
    v.dz = z;
    tbl.push_back(v);
  endtask

  function automatic logic is_zero(input logic [31:0] f);
    return f[30:23] == 8'h00;
  endfunction

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  function automatic real to_real(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'h00) begin
      d = {f[31], 63'd0};
    end else if (f[30:23] == 8'hFF) begin
      if (f[22:0] != 23'd0) d = 64'h7FF8000000000000;
      else d = {f[31], 11'h7FF, 52'd0};
    end else begin
      e = {3'b000, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_float(input real x, input logic keep_sign);
    logic [63:0] d;
    int          ef;
    logic [24:0] m;
    d = $realtobits(x);
    if (d[62:52] == 11'h7FF)
      return (d[51:0] != 52'd0) ? QNAN : {d[63], 8'hFF, 23'd0};
    if (d[62:52] == 11'h000) return {d[63], 31'd0};
    ef = int'(d[62:52]) - 896;
    m = {2'b01, d[51:29]};
    if (d[28] && ((d[27:0] != 28'd0) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      ef++;
    end
    if (ef >= 255) return {d[63], 8'hFF, 23'd0};
    if (ef <= 0) return keep_sign ? {d[63], 31'd0} : 32'h0;
    return {d[63], ef[7:0], m[22:0]};
  endfunction

  task automatic model(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r,
                       output logic z);
    real ra, rb;
    ra = to_real(a);
    rb = to_real(b);
    z = 1'b0;
    case (o)
      2'b00: r = to_float(ra + rb, 1'b0);
      2'b01: r = to_float(ra - rb, 1'b0);
      2'b10: begin
        if (is_zero(b)) begin
          z = !is_nan(a);
          if (is_nan(a) || is_zero(a)) r = QNAN;
          else r = {a[31] ^ b[31], 8'hFF, 23'd0};
        end else begin
          r = to_float(ra / rb, 1'b1);
        end
      end
      default: begin
        if (is_nan(a)) r = 32'h80000000;
        else if (ra >= 2147483648.0) r = 32'h7FFFFFFF;
        else if (ra <= -2147483648.0) r = 32'h80000000;
        else r = $rtoi(ra);
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input string nm,
                        output logic [31:0] r, output logic z);
    int lat, k;
    logic got;
    lat = (o == 2'b10) ? 30 : (o == 2'b11) ? 6 : 7;
    @(negedge clk);
    start = 1'b1;
    op = o;
    dataa = a;
    datab = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    dataa = $urandom;
    datab = $urandom;
    chkb({nm, "_busy_launch"}, busy, 1'b1);
    k = 0;
    got = 1'b0;
    while (!got && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (valid) got = 1'b1;
    end
    chk({nm, "_latency"}, 32'(k), 32'(lat));
    r = result;
    z = division_by_zero;
    chkb({nm, "_busy_done"}, busy, 1'b0);
    @(posedge clk);
    #1;
    chkb({nm, "_valid_pulse"}, valid, 1'b0);
  endtask

  function automatic logic [31:0] rnd_f(input logic [7:0] base);
    logic [31:0] r;
    int          sel;
    r = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0) begin
      case ($urandom_range(0, 5))
        0: r = 32'h00000000;
        1: r = 32'h80000000;
        2: r = 32'h7F800000;
        3: r = 32'hFF800000;
        4: r = 32'h7FC00001;
        default: r = 32'h00000123;
      endcase
    end else if (sel < 7) begin
      r[30:23] = base + 8'($urandom_range(0, 6)) - 8'd3;
    end
    return r;
  endfunction

  logic [31:0] r, er, a, b;
  logic        z, ez;
  logic [1:0]  o;
  logic [7:0]  base;
  int          nv;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    dataa = 32'h0;
    datab = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 32'h0);
    chkb("reset_valid", valid, 1'b0);
    chkb("reset_busy", busy, 1'b0);
    chkb("reset_dz", division_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    add_vec(2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);
    add_vec(2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0);
    add_vec(2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
    add_vec(2'b00, 32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0);
    add_vec(2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0);
    add_vec(2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
    add_vec(2'b00, 32'h7F800000, 32'hFF800000, QNAN, 1'b0);
    add_vec(2'b01, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b0);
    add_vec(2'b00, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0);
    add_vec(2'b01, 32'h00800000, 32'h00C00000, 32'h00000000, 1'b0);
    add_vec(2'b10, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
    add_vec(2'b10, 32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1);
    add_vec(2'b10, 32'h00000000, 32'h80000000, QNAN, 1'b1);
    add_vec(2'b10, 32'h7F800000, 32'h7F800000, QNAN, 1'b0);
    add_vec(2'b10, 32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0);
    add_vec(2'b10, 32'h7FC00000, 32'h00000000, QNAN, 1'b0);
    add_vec(2'b10, 32'h80400000, 32'h3F800000, 32'h80000000, 1'b0);
    add_vec(2'b10, 32'h3F800000, 32'h00400000, 32'h7F800000, 1'b1);
    add_vec(2'b10, 32'h00800000, 32'h4B000000, 32'h00000000, 1'b0);
    add_vec(2'b11, 32'hC0300000, 32'h00000000, 32'hFFFFFFFE, 1'b0);
    add_vec(2'b11, 32'h4F32D05E, 32'h00000000, 32'h7FFFFFFF, 1'b0);
    add_vec(2'b11, 32'h7FC00000, 32'h00000000, 32'h80000000, 1'b0);
    add_vec(2'b11, 32'hCF000000, 32'h00000000, 32'h80000000, 1'b0);
    add_vec(2'b11, 32'h4EFFFFFF, 32'h00000000, 32'h7FFFFF80, 1'b0);
    add_vec(2'b11, 32'h3F000000, 32'h00000000, 32'h00000000, 1'b0);
    add_vec(2'b11, 32'hFF800000, 32'h00000000, 32'h80000000, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i), r, z);
      chk($sformatf("vec%0d_res", i), r, tbl[i].res);
      chkb($sformatf("vec%0d_dz", i), z, tbl[i].dz);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("hold_res", result, tbl[tbl.size()-1].res);
    chkb("hold_dz", division_by_zero, tbl[tbl.size()-1].dz);

    @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    dataa = 32'h3F800000;
    datab = 32'h40400000;
    @(posedge clk);
    nv = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c <= 30) begin
        op = 2'($urandom);
        dataa = $urandom;
        datab = $urandom;
      end else if (c == 31) begin
        op = 2'b00;
        dataa = 32'h3F800000;
        datab = 32'h40000000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (valid) nv++;
      if (c == 30) begin
        chkb("b2b_valid1", valid, 1'b1);
        chk("b2b_res1", result, 32'h3EAAAAAB);
        chkb("b2b_busy_low", busy, 1'b0);
      end
      if (c == 31) begin
        chkb("b2b_relaunch", busy, 1'b1);
        chkb("b2b_valid_low", valid, 1'b0);
      end
      if (c == 38) begin
        chkb("b2b_valid2", valid, 1'b1);
        chk("b2b_res2", result, 32'h40400000);
      end
    end
    chk("b2b_count", 32'(nv), 32'd2);

    run_op(2'b10, 32'h40A00000, 32'h00000000, "pre_abort", r, z);
    chk("pre_abort_res", r, 32'h7F800000);
    chkb("pre_abort_dz", z, 1'b1);
    @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    dataa = 32'h3F800000;
    datab = 32'h40400000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_res", result, 32'h0);
    chkb("abort_valid", valid, 1'b0);
    chkb("abort_busy", busy, 1'b0);
    chkb("abort_dz", division_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid) nv++;
    end
    chk("abort_no_valid", 32'(nv), 32'd0);
    run_op(2'b00, 32'h3F800000, 32'h40000000, "post_abort", r, z);
    chk("post_abort_res", r, 32'h40400000);
    chkb("post_abort_dz", z, 1'b0);

    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      base = 8'($urandom_range(100, 160));
      a = rnd_f(base);
      b = rnd_f(base);
      model(o, a, b, er, ez);
      run_op(o, a, b, "rnd", r, z);
      chk($sformatf("rnd%0d_op%0d_%h_%h", i, o, a, b), r, er);
      chkb($sformatf("rnd%0d_dz", i), z, ez);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
